nvme_doorbell_axil_slave: RTL

AXI4-Lite slave that terminates doorbell writes issued by the SubmissionQueueManagement AXI-Lite master (M00_AXI_LITE) and is the responder for those writes. It holds one SQ-tail and one CQ-head doorbell register per queue and range-checks every write. Each accepted doorbell value is forwarded as a valid/ready event to the queue engine. It sits in the NVMe controller model and in the block-design bench as the slave at the far end of the master's AXI-Lite port.

---
 rtl/nvme_doorbell_pkg.sv | 44 ++++
 rtl/nvme_doorbell_axil_slave.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/nvme_doorbell_pkg.sv
// Shared constants, FSM state types and the address decoder used by both
// channels of the NVMe doorbell AXI4-Lite slave.
package nvme_doorbell_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] SQ_OFS  = 32'h0;
    localparam logic [31:0] CQ_OFS  = 32'h4;
    localparam logic [31:0] QSTRIDE = 32'd8;
    localparam logic [31:0] ERR_OFS = 32'h3C;

    typedef enum logic [1:0] {W_IDLE, W_EVT, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

    typedef enum logic [1:0] {DEC_NONE, DEC_SQ, DEC_CQ, DEC_ERR} dec_kind_t;

    typedef struct packed {
        dec_kind_t  kind;
        logic [1:0] qid;
    } dec_t;

    // Byte lanes [1:0] of the address are ignored; queues beyond num_queues decode as unmapped.
    function automatic dec_t decode_addr(input logic [31:0] addr, input logic [31:0] num_queues);
        logic [31:0] word_addr;
        dec_t        dec;
        word_addr = addr & ~32'd3;
        dec.kind  = DEC_NONE;
        dec.qid   = 2'd0;
        if (word_addr == ERR_OFS) begin
            dec.kind = DEC_ERR;
        end else if (word_addr < QSTRIDE * num_queues) begin
            dec.qid = 2'(word_addr / QSTRIDE);
            if ((word_addr % QSTRIDE) == SQ_OFS) begin
                dec.kind = DEC_SQ;
            end else if ((word_addr % QSTRIDE) == CQ_OFS) begin
                dec.kind = DEC_CQ;
            end
        end
        return dec;
    endfunction

endpackage

// File: rtl/nvme_doorbell_axil_slave.sv
// AXI4-Lite slave holding per-queue SQ-tail/CQ-head doorbells; every accepted
// doorbell write is forwarded to the queue engine before the write is acknowledged.
module nvme_doorbell_axil_slave
    import nvme_doorbell_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned NUM_QUEUES         = 4,
    parameter int unsigned QUEUE_DEPTH        = 64
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            DB_VALID,
    input  logic                            DB_READY,
    output logic [1:0]                      DB_QID,
    output logic                            DB_IS_CQ,
    output logic [15:0]                     DB_VALUE
);

    wr_state_t   wr_state_q, wr_state_d;
    rd_state_t   rd_state_q, rd_state_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  db_qid_q, db_qid_d;
    logic        db_is_cq_q, db_is_cq_d;
    logic [15:0] db_value_q, db_value_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [15:0] sq_q [4];
    logic [15:0] sq_d [4];
    logic [15:0] cq_q [4];
    logic [15:0] cq_d [4];

    logic aw_fire;
    dec_t wr_dec;
    dec_t rd_dec;

    assign aw_fire = (wr_state_q == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
    assign wr_dec  = decode_addr(32'(S_AXI_AWADDR), 32'(NUM_QUEUES));
    assign rd_dec  = decode_addr(32'(S_AXI_ARADDR), 32'(NUM_QUEUES));

    // Address and data are only ever accepted together, so no half-captured write can exist.
    assign S_AXI_AWREADY = aw_fire && !ARESET;
    assign S_AXI_WREADY  = aw_fire && !ARESET;
    assign S_AXI_BVALID  = (wr_state_q == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = (rd_state_q == R_IDLE) && !ARESET;
    assign S_AXI_RVALID  = (rd_state_q == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign DB_VALID      = (wr_state_q == W_EVT);
    assign DB_QID        = db_qid_q;
    assign DB_IS_CQ      = db_is_cq_q;
    assign DB_VALUE      = db_value_q;

    always_comb begin
        wr_state_d = wr_state_q;
        bresp_d    = bresp_q;
        db_qid_d   = db_qid_q;
        db_is_cq_d = db_is_cq_q;
        db_value_d = db_value_q;
        err_cnt_d  = err_cnt_q;
        sq_d       = sq_q;
        cq_d       = cq_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    if (wr_dec.kind == DEC_NONE) begin
                        bresp_d    = RESP_DECERR;
                        wr_state_d = W_RESP;
                    end else if (wr_dec.kind == DEC_ERR || S_AXI_WSTRB != 4'hF ||
                                 S_AXI_WDATA >= 32'(QUEUE_DEPTH)) begin
                        bresp_d    = RESP_SLVERR;
                        wr_state_d = W_RESP;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end else begin
                        if (wr_dec.kind == DEC_CQ) begin
                            cq_d[wr_dec.qid] = S_AXI_WDATA[15:0];
                        end else begin
                            sq_d[wr_dec.qid] = S_AXI_WDATA[15:0];
                        end
                        db_qid_d   = wr_dec.qid;
                        db_is_cq_d = (wr_dec.kind == DEC_CQ);
                        db_value_d = S_AXI_WDATA[15:0];
                        wr_state_d = W_EVT;
                    end
                end
            end
            W_EVT: begin
                if (DB_READY) begin
                    bresp_d    = RESP_OKAY;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Reads sample the registered state, so a same-cycle write or error count is not yet visible.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    rd_state_d = R_DATA;
                    rresp_d    = RESP_OKAY;
                    case (rd_dec.kind)
                        DEC_SQ:  rdata_d = {16'h0, sq_q[rd_dec.qid]};
                        DEC_CQ:  rdata_d = {16'h0, cq_q[rd_dec.qid]};
                        DEC_ERR: rdata_d = {24'h0, err_cnt_q};
                        default: begin
                            rdata_d = 32'h0;
                            rresp_d = RESP_DECERR;
                        end
                    endcase
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            bresp_q    <= 2'b00;
            rresp_q    <= 2'b00;
            rdata_q    <= 32'h0;
            db_qid_q   <= 2'd0;
            db_is_cq_q <= 1'b0;
            db_value_q <= 16'h0;
            err_cnt_q  <= 8'h0;
            sq_q       <= '{default: 16'h0};
            cq_q       <= '{default: 16'h0};
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            db_qid_q   <= db_qid_d;
            db_is_cq_q <= db_is_cq_d;
            db_value_q <= db_value_d;
            err_cnt_q  <= err_cnt_d;
            sq_q       <= sq_d;
            cq_q       <= cq_d;
        end
    end

endmodule
